rv32i_fetch: RTL

RV32I_FETCH -- requirements
Module: rv32i_fetch

---
 rtl/rv32i_fetch_if.sv | 33 +++
 rtl/rv32i_fetch.sv | 92 +++++++++
 2 files changed

// File: rtl/rv32i_fetch_if.sv
// rv32i_fetch_if: instruction ROM port plus
// the valid/ready instruction stream toward decode.
interface rv32i_fetch_if #(
  parameter int ADDR_W = 5
);
  logic              imem_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instr;
  logic [31:0]       instr_pc;

  modport slave (
    output imem_en,
    output imem_addr,
    input  imem_rdata,
    output instr_valid,
    input  instr_ready,
    output instr,
    output instr_pc
  );

  modport master (
    input  imem_en,
    input  imem_addr,
    output imem_rdata,
    input  instr_valid,
    output instr_ready,
    input  instr,
    input  instr_pc
  );
endinterface

// File: rtl/rv32i_fetch.sv
// rv32i_fetch: PC sequencer with a prefetch FIFO,
// redirect/flush and a sticky misaligned-target flag.
module rv32i_fetch #(
  parameter int          ADDR_W   = 5,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  rv32i_fetch_if.slave             bus,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic [31:0]              fetch_pc,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     fault
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] FULL = DEPTH[CW:0];

  logic          inflight;
  logic [31:0]   inflight_pc;
  logic [31:0]   mem_i [DEPTH];
  logic [31:0]   mem_p [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          pop;
  logic          push;
  logic          issue;
  logic [CW:0]   occ;

  assign pop   = bus.instr_valid & bus.instr_ready;
  assign push  = reset & inflight & ~redirect;
  assign occ   = {1'b0, count}
               + {{CW{1'b0}}, inflight}
               - {{CW{1'b0}}, pop};
  assign issue = reset & ~fault & ~redirect
               & (occ < FULL);

  assign bus.imem_en     = issue;
  assign bus.imem_addr   = fetch_pc[ADDR_W+1:2];
  assign bus.instr_valid = (count != '0);
  assign bus.instr       = mem_i[rd_ptr];
  assign bus.instr_pc    = mem_p[rd_ptr];

  // PC, in-flight tracking, FIFO pointers and fault flag
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= RESET_PC;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fault       <= 1'b0;
    end else if (redirect) begin
      inflight <= 1'b0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      if (redirect_pc[1:0] == 2'b00) begin
        fetch_pc <= redirect_pc;
        fault    <= 1'b0;
      end else begin
        fault    <= 1'b1;
      end
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc    <= fetch_pc + 32'd4;
        inflight_pc <= fetch_pc;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage: returning word paired with its PC
  always_ff @(posedge clk) begin
    if (push) begin
      mem_i[wr_ptr] <= bus.imem_rdata;
      mem_p[wr_ptr] <= inflight_pc;
    end
  end

endmodule
